// File: rtl/conv_patch_gen_if.sv
// Pixel-in / patch-out stream bundle for the 3x3 window generator.
// Optional patch_last flag is present only when PATCH_LAST_EN is defined.
interface conv_patch_gen_if #(
  parameter int DATA_W = 16
);
  logic                  in_valid;
  logic                  in_sof;
  logic [DATA_W-1:0]     in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [9*DATA_W-1:0]   PATCH;
`ifdef PATCH_LAST_EN
  logic                  patch_last;
`endif

  // Pixel source / patch sink side
  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  in_ready, out_valid, PATCH
`ifdef PATCH_LAST_EN
    , input patch_last
`endif
  );

  // Window generator side
  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, PATCH
`ifdef PATCH_LAST_EN
    , output patch_last
`endif
  );
endinterface

// File: rtl/conv_patch_gen.sv
// Streaming 3x3 window generator feeding conv_3_3.
// Two line buffers hold the previous two rows; a 3x3 register window shifts
// left on every accepted pixel and a patch is emitted for every interior
// position (row >= 2, col >= 2) of the frame.
// Optional feature macro: PATCH_LAST_EN (adds registered patch_last flag on
// the patch at the bottom-right corner of the frame).
module conv_patch_gen #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
) (
  input  logic             CLK,
  input  logic             rst_n,
  conv_patch_gen_if.slave  bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]     col_q, cur_col, col_nxt;
  logic [RW-1:0]     row_q, cur_row, row_nxt;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] top_new, mid_new;
  logic [9*DATA_W-1:0] patch_q, patch_d;
  logic              out_valid_q;
  logic              accept, emit;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.PATCH     = patch_q;
  assign accept        = bus.in_valid && bus.in_ready;

  // Position of the pixel being accepted; in_sof forces it to (0,0), then
  // the counters step and wrap for the following pixel.
  always_comb begin
    cur_col = bus.in_sof ? '0 : col_q;
    cur_row = bus.in_sof ? '0 : row_q;
    col_nxt = cur_col + CW'(1);
    row_nxt = cur_row;
    if (cur_col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
    end
    emit = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  end

  // New right column and the packed patch it completes; p00 lands in the MSBs.
  always_comb begin
    top_new = lb1[cur_col];
    mid_new = lb0[cur_col];
    patch_d = {win_q[0][1], win_q[0][2], top_new,
               win_q[1][1], win_q[1][2], mid_new,
               win_q[2][1], win_q[2][2], bus.in_data};
  end

  // Line buffers: the row above moves up, the new pixel fills the bottom one.
  // Not reset -- rows 0 and 1 never emit, so stale contents are masked.
  always_ff @(posedge CLK) begin
    if (accept) begin
      lb1[cur_col] <= lb0[cur_col];
      lb0[cur_col] <= bus.in_data;
    end
  end

  // Raster position counters.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      col_q <= col_nxt;
      row_q <= row_nxt;
    end
  end

  // 3x3 window: shift left, load the new right column.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= top_new;
      win_q[1][2] <= mid_new;
      win_q[2][2] <= bus.in_data;
    end
  end

  // Output register: load on emit, clear on handshake without a new emit,
  // hold under backpressure (no pixel is accepted while stalled).
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      patch_q     <= '0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      patch_q     <= patch_d;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef PATCH_LAST_EN
  logic last_q;
  assign bus.patch_last = last_q;

  // Bottom-right patch flag, registered alongside PATCH.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)
      last_q <= 1'b0;
    else if (emit)
      last_q <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
  end
`else
  // No end-of-frame flag in this build.
`endif

endmodule

// File: tb/tb_conv_patch_gen.sv
// Directed bench for conv_patch_gen at IMG_W=5, IMG_H=4, pixel value = row*5+col.
module tb_conv_patch_gen;
  localparam int DATA_W = 16;
  localparam int PW     = 9 * DATA_W;

  localparam logic [PW-1:0] P_FIRST  = {16'd0, 16'd1, 16'd2, 16'd5, 16'd6, 16'd7, 16'd10, 16'd11, 16'd12};
  localparam logic [PW-1:0] P_SECOND = {16'd1, 16'd2, 16'd3, 16'd6, 16'd7, 16'd8, 16'd11, 16'd12, 16'd13};
  localparam logic [PW-1:0] P_LAST   = {16'd7, 16'd8, 16'd9, 16'd12, 16'd13, 16'd14, 16'd17, 16'd18, 16'd19};

  logic CLK = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic [PW-1:0] q_patch[$];
  logic          q_last[$];

  conv_patch_gen_if #(.DATA_W(DATA_W)) bus ();

  conv_patch_gen #(.DATA_W(DATA_W), .IMG_W(5), .IMG_H(4)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Inputs change at posedge+2, so at the negedge they are stable up to the
  // next posedge: a visible out_valid && out_ready is the coming handshake.
  always @(negedge CLK) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      q_patch.push_back(bus.PATCH);
`ifdef PATCH_LAST_EN
      q_last.push_back(bus.patch_last);
`else
      q_last.push_back(1'b0);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] exp_patch(input int r0, input int c0);
    logic [PW-1:0] x = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        x = {x[PW-DATA_W-1:0], DATA_W'((r0 + r) * 5 + (c0 + c))};
    return x;
  endfunction

  task automatic send(input int v, input bit sof);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(v);
    bus.in_sof   = sof;
    @(negedge CLK);
    while (!bus.in_ready && guard < 200) begin
      guard++;
      @(negedge CLK);
    end
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL send_timeout observed=in_ready_low required=accept pixel %0d", v);
    end
    @(posedge CLK);
    #2;
    bus.in_sof = 1'b0;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    @(posedge CLK);
    #2;
  endtask

  task automatic send_frame(input bit sof, input bit gap);
    for (int k = 0; k < 20; k++) begin
      send(k, sof && (k == 0));
      if (gap) idle();
    end
  endtask

  task automatic check_frames(input string tag, input int nframes);
    chk({tag, "_count"}, PW'(q_patch.size()), PW'(6 * nframes));
    for (int f = 0; f < nframes; f++)
      for (int i = 0; i < 6; i++)
        if (f * 6 + i < q_patch.size()) begin
          chk($sformatf("%s_patch%0d", tag, f * 6 + i), q_patch[f * 6 + i], exp_patch(i / 3, i % 3));
`ifdef PATCH_LAST_EN
          chk($sformatf("%s_last%0d", tag, f * 6 + i), PW'(q_last[f * 6 + i]), PW'(i == 5));
`endif
        end
    q_patch.delete();
    q_last.delete();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_out_valid", PW'(bus.out_valid), PW'(0));
    chk("rst_patch", bus.PATCH, '0);
    chk("rst_in_ready", PW'(bus.in_ready), PW'(1));
    rst_n = 1'b1;
    @(posedge CLK);
    #2;

    // Basic frame: first patch right after pixel 12, last patch at pixel 19.
    for (int k = 0; k < 12; k++) send(k, k == 0);
    chk("pre12_out_valid", PW'(bus.out_valid), PW'(0));
    send(12, 1'b0);
    chk("first_out_valid", PW'(bus.out_valid), PW'(1));
    chk("first_patch", bus.PATCH, P_FIRST);
    for (int k = 13; k < 20; k++) send(k, 1'b0);
    chk("last_patch", bus.PATCH, P_LAST);
    repeat (3) idle();
    chk("drain_out_valid", PW'(bus.out_valid), PW'(0));
    check_frames("basic", 1);

    // Back-to-back frames, second frame relies on counter wrap (no sof).
    send_frame(1'b1, 1'b0);
    send_frame(1'b0, 1'b0);
    repeat (3) idle();
    check_frames("b2b", 2);

    // in_valid toggling every other cycle.
    send_frame(1'b1, 1'b1);
    repeat (3) idle();
    check_frames("toggle", 1);

    // Backpressure at the first patch for 4 cycles.
    for (int k = 0; k < 12; k++) send(k, k == 0);
    bus.out_ready = 1'b0;
    send(12, 1'b0);
    chk("bp_out_valid", PW'(bus.out_valid), PW'(1));
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(13);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk($sformatf("bp_in_ready%0d", i), PW'(bus.in_ready), PW'(0));
      chk($sformatf("bp_hold%0d", i), bus.PATCH, P_FIRST);
    end
    @(posedge CLK);
    #2;
    bus.out_ready = 1'b1;
    for (int k = 13; k < 20; k++) send(k, 1'b0);
    repeat (3) idle();
    if (q_patch.size() > 1) chk("bp_second", q_patch[1], P_SECOND);
    check_frames("bp", 1);

    // Resync: partial frame of 7 pixels, then a fresh frame with sof.
    for (int k = 0; k < 7; k++) send(k, k == 0);
    chk("resync_no_emit", PW'(q_patch.size()), PW'(0));
    send_frame(1'b1, 1'b0);
    repeat (3) idle();
    if (q_patch.size() > 0) chk("resync_first", q_patch[0], P_FIRST);
    check_frames("resync", 1);

    // Reset with a pending patch after pixel 14.
    for (int k = 0; k < 15; k++) send(k, k == 0);
    chk("pend_out_valid", PW'(bus.out_valid), PW'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", PW'(bus.out_valid), PW'(0));
    chk("midrst_patch", bus.PATCH, '0);
    q_patch.delete();
    q_last.delete();
    bus.in_valid = 1'b0;
    @(posedge CLK);
    #2;
    rst_n = 1'b1;
    idle();
    send_frame(1'b0, 1'b0);
    repeat (3) idle();
    check_frames("postrst", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
